// File: rtl/lsu_pkg.sv
// +----------------------------------------------------------------------+
// | lsu_pkg : shared constants, FSM encoding and helpers for the LSU      |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

package lsu_pkg;

  localparam int unsigned NUM_LANES = 4;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] REQ  = 2'd1;
  localparam logic [1:0] RESP = 2'd2;

  function automatic logic f3_legal(input logic is_load, input logic [2:0] f3);
    if (is_load)
      return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W) || (f3 == F3_BU) || (f3 == F3_HU);
    else
      return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W);
  endfunction

  // funct3[1:0] encodes access size; sub-size offset bits are dropped so lanes stay in-word
  function automatic logic [1:0] lane_offset(input logic [1:0] size, input logic [1:0] a);
    case (size)
      2'b00:   return a;
      2'b01:   return {a[1], 1'b0};
      default: return 2'b00;
    endcase
  endfunction

  function automatic logic misaligned(input logic [1:0] size, input logic [1:0] a);
    return ((size == 2'b01) && a[0]) || ((size == 2'b10) && (a != 2'b00));
  endfunction

endpackage

`default_nettype wire

// File: rtl/lsu_load_align.sv
// +----------------------------------------------------------------------+
// | lsu_load_align : selects the load lane and sign/zero-extends it      |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

module lsu_load_align
  import lsu_pkg::*;
#(
  parameter int WORD_SIZE = 32
) (
  input  logic [WORD_SIZE-1:0] rdata_i,
  input  logic [1:0]           offset_i,
  input  logic [2:0]           funct3_i,
  output logic [WORD_SIZE-1:0] data_o
);

  logic [WORD_SIZE-1:0] w_shifted;

  assign w_shifted = rdata_i >> {offset_i, 3'b000};

  always_comb begin
    data_o = rdata_i;
    case (funct3_i)
      F3_B:    data_o = {{(WORD_SIZE-8){w_shifted[7]}}, w_shifted[7:0]};
      F3_BU:   data_o = {{(WORD_SIZE-8){1'b0}}, w_shifted[7:0]};
      F3_H:    data_o = {{(WORD_SIZE-16){w_shifted[15]}}, w_shifted[15:0]};
      F3_HU:   data_o = {{(WORD_SIZE-16){1'b0}}, w_shifted[15:0]};
      default: data_o = rdata_i;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/lsu.sv
// +----------------------------------------------------------------------+
// | lsu : single-outstanding load/store unit between execute and memory  |
// | Optional: LSU_MISALIGN_TRAP_EN enables the misalignment trap.         |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

module lsu
  import lsu_pkg::*;
#(
  parameter int WORD_SIZE = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 ex_valid,
  output logic                 ex_ready,
  input  logic                 ex_is_load,
  input  logic                 ex_is_store,
  input  logic [2:0]           ex_funct3,
  input  logic [WORD_SIZE-1:0] ex_addr,
  input  logic [WORD_SIZE-1:0] ex_wdata,
  output logic                 mem_req_valid,
  input  logic                 mem_req_ready,
  output logic                 mem_we,
  output logic [NUM_LANES-1:0] mem_be,
  output logic [WORD_SIZE-1:0] mem_addr,
  output logic [WORD_SIZE-1:0] mem_wdata,
  input  logic                 mem_rsp_valid,
  input  logic [WORD_SIZE-1:0] mem_rdata,
  output logic                 wb_valid,
  output logic [WORD_SIZE-1:0] wb_data,
  output logic                 done,
  output logic                 exc_misaligned
);

  logic [1:0]           state_q, state_d;
  logic [WORD_SIZE-1:0] addr_q, addr_d;
  logic [WORD_SIZE-1:0] wdata_q, wdata_d;
  logic [2:0]           funct3_q, funct3_d;
  logic                 is_load_q, is_load_d;
  logic                 done_q, done_d;
  logic                 wb_valid_q, wb_valid_d;
  logic [WORD_SIZE-1:0] wb_data_q, wb_data_d;

  logic                 w_accept;
  logic                 w_legal;
  logic                 w_misalign;
  logic [1:0]           w_off;
  logic [WORD_SIZE-1:0] w_load_word;

  // A load+store request is a load, so is_load alone selects the legality table
  assign w_accept = ex_valid && ex_ready && (ex_is_load || ex_is_store);
  assign w_legal  = f3_legal(ex_is_load, ex_funct3);

`ifdef LSU_MISALIGN_TRAP_EN
  logic exc_q, exc_d;
  assign w_misalign     = misaligned(ex_funct3[1:0], ex_addr[1:0]);
  assign exc_misaligned = exc_q;
`else
  assign w_misalign     = 1'b0;
  assign exc_misaligned = 1'b0;
`endif

  assign w_off = lane_offset(funct3_q[1:0], addr_q[1:0]);

  lsu_load_align #(
    .WORD_SIZE (WORD_SIZE)
  ) u_load_align (
    .rdata_i  (mem_rdata),
    .offset_i (w_off),
    .funct3_i (funct3_q),
    .data_o   (w_load_word)
  );

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    funct3_d   = funct3_q;
    is_load_d  = is_load_q;
    done_d     = 1'b0;
    wb_valid_d = 1'b0;
    wb_data_d  = wb_data_q;
`ifdef LSU_MISALIGN_TRAP_EN
    exc_d      = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (w_accept) begin
          addr_d    = ex_addr;
          wdata_d   = ex_wdata;
          funct3_d  = ex_funct3;
          is_load_d = ex_is_load;
          if (!w_legal || w_misalign) begin
            done_d = 1'b1;
`ifdef LSU_MISALIGN_TRAP_EN
            exc_d  = w_legal;
`endif
          end else begin
            state_d = REQ;
          end
        end
      end
      REQ: begin
        if (mem_req_ready) begin
          if (is_load_q) begin
            state_d = RESP;
          end else begin
            done_d  = 1'b1;
            state_d = IDLE;
          end
        end
      end
      RESP: begin
        if (mem_rsp_valid) begin
          wb_valid_d = 1'b1;
          done_d     = 1'b1;
          wb_data_d  = w_load_word;
          state_d    = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      wdata_q    <= '0;
      funct3_q   <= '0;
      is_load_q  <= 1'b0;
      done_q     <= 1'b0;
      wb_valid_q <= 1'b0;
      wb_data_q  <= '0;
`ifdef LSU_MISALIGN_TRAP_EN
      exc_q      <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      funct3_q   <= funct3_d;
      is_load_q  <= is_load_d;
      done_q     <= done_d;
      wb_valid_q <= wb_valid_d;
      wb_data_q  <= wb_data_d;
`ifdef LSU_MISALIGN_TRAP_EN
      exc_q      <= exc_d;
`endif
    end
  end

  assign ex_ready      = (state_q == IDLE);
  assign mem_req_valid = (state_q == REQ);
  assign mem_addr      = {addr_q[WORD_SIZE-1:2], 2'b00};
  assign wb_valid      = wb_valid_q;
  assign wb_data       = wb_data_q;
  assign done          = done_q;

  always_comb begin
    mem_we    = 1'b0;
    mem_be    = '0;
    mem_wdata = '0;
    if (state_q == REQ) begin
      mem_we = !is_load_q;
      if (is_load_q) begin
        mem_be = 4'b1111;
      end else begin
        case (funct3_q[1:0])
          2'b00: begin
            mem_be    = 4'b0001 << w_off;
            mem_wdata = {4{wdata_q[7:0]}};
          end
          2'b01: begin
            mem_be    = 4'b0011 << w_off;
            mem_wdata = {2{wdata_q[15:0]}};
          end
          default: begin
            mem_be    = 4'b1111;
            mem_wdata = wdata_q;
          end
        endcase
      end
    end
  end

  a_req_hold: assert property (@(posedge clk) disable iff (!rst_n)
    (mem_req_valid && !mem_req_ready) |=> mem_req_valid);

endmodule

`default_nettype wire

// File: tb/tb_lsu.sv
// +----------------------------------------------------------------------+
// | tb_lsu : vector table plus scoreboard for the load/store unit        |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

module tb_lsu;
  import lsu_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        ex_valid = 1'b0;
  logic        ex_ready;
  logic        ex_is_load = 1'b0;
  logic        ex_is_store = 1'b0;
  logic [2:0]  ex_funct3 = '0;
  logic [31:0] ex_addr = '0;
  logic [31:0] ex_wdata = '0;
  logic        mem_req_valid;
  logic        mem_req_ready = 1'b0;
  logic        mem_we;
  logic [3:0]  mem_be;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_rsp_valid = 1'b0;
  logic [31:0] mem_rdata = '0;
  logic        wb_valid;
  logic [31:0] wb_data;
  logic        done;
  logic        exc_misaligned;

  lsu #(.WORD_SIZE(32)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .ex_valid       (ex_valid),
    .ex_ready       (ex_ready),
    .ex_is_load     (ex_is_load),
    .ex_is_store    (ex_is_store),
    .ex_funct3      (ex_funct3),
    .ex_addr        (ex_addr),
    .ex_wdata       (ex_wdata),
    .mem_req_valid  (mem_req_valid),
    .mem_req_ready  (mem_req_ready),
    .mem_we         (mem_we),
    .mem_be         (mem_be),
    .mem_addr       (mem_addr),
    .mem_wdata      (mem_wdata),
    .mem_rsp_valid  (mem_rsp_valid),
    .mem_rdata      (mem_rdata),
    .wb_valid       (wb_valid),
    .wb_data        (wb_data),
    .done           (done),
    .exc_misaligned (exc_misaligned)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        ld;
    logic        st;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    int          stall;
    int          delay;
    logic        mem;
    logic [3:0]  be;
    logic [31:0] mwdata;
    logic        wbv;
    logic [31:0] wbd;
    logic        exc;
  } vec_t;

  typedef struct {
    logic        wbv;
    logic [31:0] wbd;
    logic        exc;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc = 0;

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic run(input vec_t v);
    int          acc;
    int          k;
    int          exp_lat;
    exp_t        e;
    logic [31:0] maddr;
    maddr   = {v.addr[31:2], 2'b00};
    exp_lat = !v.mem ? 1 : (v.ld ? 3 + v.stall + v.delay : 2 + v.stall);
    ex_valid    = 1'b1;
    ex_is_load  = v.ld;
    ex_is_store = v.st;
    ex_funct3   = v.f3;
    ex_addr     = v.addr;
    ex_wdata    = v.wdata;
    chk("ex_ready_idle", {31'd0, ex_ready}, 32'd1);
    acc = cyc;
    tick();
    ex_valid    = 1'b0;
    ex_is_load  = 1'b0;
    ex_is_store = 1'b0;
    sb.push_back('{v.wbv, v.wbd, v.exc});
    if (v.mem) begin
      chk("done_clear", {31'd0, done}, 32'd0);
      chk("wb_clear", {31'd0, wb_valid}, 32'd0);
      for (int i = 0; i <= v.stall; i++) begin
        mem_req_ready = (i == v.stall);
        chk("req_valid", {31'd0, mem_req_valid}, 32'd1);
        chk("req_addr", mem_addr, maddr);
        chk("req_be", {28'd0, mem_be}, {28'd0, v.be});
        chk("req_we", {31'd0, mem_we}, {31'd0, !v.ld});
        if (!v.ld) chk("req_wdata", mem_wdata, v.mwdata);
        tick();
      end
      mem_req_ready = 1'b0;
      if (v.ld) begin
        chk("req_dropped", {31'd0, mem_req_valid}, 32'd0);
        for (int i = 0; i < v.delay; i++) begin
          chk("wb_early", {31'd0, wb_valid}, 32'd0);
          tick();
        end
        mem_rsp_valid = 1'b1;
        mem_rdata     = v.rdata;
        tick();
        mem_rsp_valid = 1'b0;
        mem_rdata     = '0;
      end
    end else begin
      chk("no_req", {31'd0, mem_req_valid}, 32'd0);
    end
    k = 0;
    while (!done && k < 10) begin
      tick();
      k++;
    end
    chk("done", {31'd0, done}, 32'd1);
    chk("latency", cyc - acc, exp_lat);
    e = sb.pop_front();
    chk("wb_valid", {31'd0, wb_valid}, {31'd0, e.wbv});
    if (e.wbv) chk("wb_data", wb_data, e.wbd);
    chk("exc", {31'd0, exc_misaligned}, {31'd0, e.exc});
  endtask

  initial begin
    // ld st f3 addr wdata rdata stall delay mem be mwdata wbv wbd exc
    vecs.push_back('{1'b0, 1'b1, F3_W,  32'h1000_0004, 32'hDEAD_BEEF, 32'h0, 0, 0, 1'b1, 4'b1111, 32'hDEAD_BEEF, 1'b0, 32'h0, 1'b0});
    vecs.push_back('{1'b0, 1'b1, F3_B,  32'h0000_0103, 32'h0000_00A5, 32'h0, 0, 0, 1'b1, 4'b1000, 32'hA5A5_A5A5, 1'b0, 32'h0, 1'b0});
    vecs.push_back('{1'b0, 1'b1, F3_H,  32'h0000_2002, 32'h1234_BEEF, 32'h0, 0, 0, 1'b1, 4'b1100, 32'hBEEF_BEEF, 1'b0, 32'h0, 1'b0});
    vecs.push_back('{1'b0, 1'b1, F3_B,  32'h0000_0002, 32'h0000_0055, 32'h0, 1, 0, 1'b1, 4'b0100, 32'h5555_5555, 1'b0, 32'h0, 1'b0});
    vecs.push_back('{1'b1, 1'b0, F3_B,  32'h0000_3002, 32'h0, 32'h0080_0000, 0, 0, 1'b1, 4'b1111, 32'h0, 1'b1, 32'hFFFF_FF80, 1'b0});
    vecs.push_back('{1'b1, 1'b0, F3_BU, 32'h0000_3002, 32'h0, 32'h0080_0000, 0, 0, 1'b1, 4'b1111, 32'h0, 1'b1, 32'h0000_0080, 1'b0});
    vecs.push_back('{1'b1, 1'b0, F3_HU, 32'h0000_3002, 32'h0, 32'h8001_0000, 0, 0, 1'b1, 4'b1111, 32'h0, 1'b1, 32'h0000_8001, 1'b0});
    vecs.push_back('{1'b1, 1'b0, F3_H,  32'h0000_3002, 32'h0, 32'h8001_0000, 0, 0, 1'b1, 4'b1111, 32'h0, 1'b1, 32'hFFFF_8001, 1'b0});
    vecs.push_back('{1'b1, 1'b0, F3_H,  32'h0000_3000, 32'h0, 32'h1234_F00F, 0, 1, 1'b1, 4'b1111, 32'h0, 1'b1, 32'hFFFF_F00F, 1'b0});
    vecs.push_back('{1'b1, 1'b0, F3_B,  32'h0000_0001, 32'h0, 32'h0000_7F00, 0, 0, 1'b1, 4'b1111, 32'h0, 1'b1, 32'h0000_007F, 1'b0});
    vecs.push_back('{1'b1, 1'b0, F3_W,  32'h0000_4000, 32'h0, 32'hCAFE_F00D, 3, 2, 1'b1, 4'b1111, 32'h0, 1'b1, 32'hCAFE_F00D, 1'b0});
    vecs.push_back('{1'b1, 1'b1, F3_W,  32'h0000_7000, 32'h0, 32'h0BAD_C0DE, 0, 0, 1'b1, 4'b1111, 32'h0, 1'b1, 32'h0BAD_C0DE, 1'b0});
    vecs.push_back('{1'b1, 1'b0, 3'b011, 32'h0000_0010, 32'h0, 32'h0, 0, 0, 1'b0, 4'b0000, 32'h0, 1'b0, 32'h0, 1'b0});
    vecs.push_back('{1'b0, 1'b1, 3'b100, 32'h0000_0010, 32'h0, 32'h0, 0, 0, 1'b0, 4'b0000, 32'h0, 1'b0, 32'h0, 1'b0});
`ifdef LSU_MISALIGN_TRAP_EN
    vecs.push_back('{1'b1, 1'b0, F3_W,  32'h0000_5002, 32'h0, 32'h1122_3344, 0, 0, 1'b0, 4'b0000, 32'h0, 1'b0, 32'h0, 1'b1});
    vecs.push_back('{1'b0, 1'b1, F3_H,  32'h0000_6001, 32'h0000_ABCD, 32'h0, 0, 0, 1'b0, 4'b0000, 32'h0, 1'b0, 32'h0, 1'b1});
`else
    vecs.push_back('{1'b1, 1'b0, F3_W,  32'h0000_5002, 32'h0, 32'h1122_3344, 0, 0, 1'b1, 4'b1111, 32'h0, 1'b1, 32'h1122_3344, 1'b0});
    vecs.push_back('{1'b0, 1'b1, F3_H,  32'h0000_6001, 32'h0000_ABCD, 32'h0, 0, 0, 1'b1, 4'b0011, 32'hABCD_ABCD, 1'b0, 32'h0, 1'b0});
`endif

    rst_n = 1'b0;
    tick();
    tick();
    chk("rst_ex_ready", {31'd0, ex_ready}, 32'd1);
    chk("rst_req_valid", {31'd0, mem_req_valid}, 32'd0);
    chk("rst_mem_addr", mem_addr, 32'd0);
    chk("rst_mem_be", {28'd0, mem_be}, 32'd0);
    chk("rst_mem_we", {31'd0, mem_we}, 32'd0);
    chk("rst_mem_wdata", mem_wdata, 32'd0);
    chk("rst_wb_valid", {31'd0, wb_valid}, 32'd0);
    chk("rst_wb_data", wb_data, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_exc", {31'd0, exc_misaligned}, 32'd0);
    rst_n = 1'b1;
    tick();

    // Valid with neither load nor store must be ignored
    ex_valid = 1'b1;
    ex_addr  = 32'h0000_0ABC;
    tick();
    ex_valid = 1'b0;
    chk("ign_ex_ready", {31'd0, ex_ready}, 32'd1);
    chk("ign_req_valid", {31'd0, mem_req_valid}, 32'd0);
    chk("ign_done", {31'd0, done}, 32'd0);
    tick();
    chk("ign_done2", {31'd0, done}, 32'd0);

    // Each op starts in the cycle the previous done is high (back-to-back)
    foreach (vecs[i]) run(vecs[i]);
    tick();
    chk("idle_done_clear", {31'd0, done}, 32'd0);

    // Reset while waiting for the load response
    ex_valid   = 1'b1;
    ex_is_load = 1'b1;
    ex_funct3  = F3_W;
    ex_addr    = 32'h0000_8000;
    tick();
    ex_valid      = 1'b0;
    ex_is_load    = 1'b0;
    mem_req_ready = 1'b1;
    tick();
    mem_req_ready = 1'b0;
    chk("resp_ex_ready", {31'd0, ex_ready}, 32'd0);
    chk("resp_req_valid", {31'd0, mem_req_valid}, 32'd0);
    rst_n = 1'b0;
    tick();
    chk("rstmid_ex_ready", {31'd0, ex_ready}, 32'd1);
    rst_n         = 1'b1;
    mem_rsp_valid = 1'b1;
    mem_rdata     = 32'h7777_7777;
    tick();
    mem_rsp_valid = 1'b0;
    mem_rdata     = '0;
    chk("rstmid_wb_valid", {31'd0, wb_valid}, 32'd0);
    chk("rstmid_done", {31'd0, done}, 32'd0);
    chk("rstmid_ex_ready2", {31'd0, ex_ready}, 32'd1);
    chk("rstmid_req_valid", {31'd0, mem_req_valid}, 32'd0);
    tick();
    chk("rstmid_wb_valid2", {31'd0, wb_valid}, 32'd0);

    run(vecs[0]);
    run(vecs[4]);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
